mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Target-side model of the CPU external memory bus. It answers the CPU's byte-wide `mem_a`/`mem_dout`/`mem_wr`/`mem_din` traffic.
- Provides a 128KB byte RAM with 1-cycle read latency, plus a memory-mapped I/O window:
  - UART RX input,
  - UART TX output through a FIFO,
  - a free-running cycle counter,
  - a program-stop register.
- Drives `io_buffer_full` back to the CPU.
- Sits opposite `cpu` in the simulation/FPGA top level.

Parameters:
- RAM_ADDR_BITS, 17, RAM byte-address width (RAM size = 2^RAM_ADDR_BITS bytes).
- TX_DEPTH, 8, TX FIFO entries; must be a power of 2, at least 4.
- FULL_MARGIN, 2, `io_buffer_full` asserts when free TX entries <= FULL_MARGIN.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- cpu_a  in  32  bus address from CPU (`mem_a`)
- cpu_wr  in  1  1 = write, 0 = read (`mem_wr`)
- cpu_wdata  in  8  write data from CPU (`mem_dout`)
- cpu_rdata  out  8  read data to CPU (`mem_din`), registered
- io_buffer_full  out  1  TX FIFO near full
- rx_data  in  8  received UART byte
- rx_valid  in  1  rx_data holds an unread byte
- rx_ready  out  1  consume pulse for rx_data
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  UART accepts tx_data
- halted  out  1  program stop complete

Behaviour:
- Reset values (cycle after `rst_in`=1): cpu_rdata=0, rx_ready=0, tx_valid=0, io_buffer_full=0, halted=0. FIFO is emptied, cycle counter=0, state=RUN. RAM contents are not cleared.
- Reset mid-operation discards queued TX bytes and any pending stop.
- Address decode:
  - IO when cpu_a[17:16]==2'b11; upper bits are ignored.
  - Otherwise RAM at index cpu_a[RAM_ADDR_BITS-1:0].
- Every cycle is an access; the bus has no idle qualifier.
- RAM read: cpu_rdata <= ram[idx] at the clock edge, so data is visible the cycle after the address.
- RAM write: ram[idx] <= cpu_wdata at the edge; cpu_rdata holds its previous value.
- Cycle counter: 32-bit, increments every non-reset cycle, wraps from 0xFFFFFFFF to 0.
- IO reads:
  - 0x30000:
    - If rx_valid: cpu_rdata <= rx_data, and rx_ready=1 combinationally in the same cycle (one byte consumed per read cycle).
    - Else cpu_rdata <= 0x00 and rx_ready=0.
  - 0x30004: snap <= counter; cpu_rdata <= counter[7:0].
  - 0x30005 / 0x30006 / 0x30007: cpu_rdata <= snap[15:8] / snap[23:16] / snap[31:24].
  - Any other IO address: cpu_rdata <= 0.
- IO writes (RUN state only):
  - 0x30000 with nonzero data: push onto the TX FIFO.
  - 0x30000 with 0x00: ignored.
  - 0x30004, any data: push 0x00 onto the FIFO, then state <= DRAIN.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped.
  - Other IO addresses: ignored.
- TX FIFO:
  - tx_data = head, tx_valid = count != 0.
  - Pop on tx_valid & tx_ready.
  - Simultaneous push and pop: both take effect, count unchanged. A push into a full FIFO with a same-cycle pop is accepted.
  - Pointers wrap modulo TX_DEPTH.
  - Count width is log2(TX_DEPTH)+1.
- io_buffer_full = (TX_DEPTH - count) <= FULL_MARGIN, registered from the next-count value.
- State machine:
  - RUN -> DRAIN on a stop write. The stop byte must enter the FIFO: if the FIFO is full with no pop, the stop write is dropped and the state stays RUN.
  - DRAIN: IO writes are ignored; RAM writes and all reads still work. DRAIN -> HALTED when count==0.
  - HALTED: halted=1; all writes (RAM and IO) are ignored; reads still work. Exit only via reset.

Optional Feature:
- Macro: MEMIO_ERR_FLAG_EN.
- Defined:
  - Adds output `bus_err` (1 bit, reset 0, sticky).
  - Set the cycle after any non-IO access with cpu_a[31:RAM_ADDR_BITS] != 0, any IO access to an undefined address, or a TX push dropped on full.
  - Offending accesses otherwise behave as without the macro.
- Undefined: no `bus_err` port. Out-of-range RAM addresses alias to their low RAM_ADDR_BITS bits; drops are silent.

Test Plan:
- RAM latency: write 0xA5 to 0x00010, then read 0x00010 -> cpu_rdata==0xA5 exactly one cycle after the read address is presented; cpu_rdata unchanged during the write cycle.
- RX path: rx_valid=1, rx_data=0x41, read 0x30000 -> rx_ready pulses for 1 cycle, cpu_rdata==0x41 next cycle. Repeat with rx_valid=0 -> cpu_rdata==0x00, rx_ready=0.
- Counter snapshot: read 0x30004..0x30007 on consecutive cycles starting at counter==0x000001FF -> bytes 0xFF, 0x01, 0x00, 0x00 (snapshot values, not live counter).
- TX FIFO, TX_DEPTH=8, FULL_MARGIN=2, tx_ready=0: write 0x31..0x38 to 0x30000, plus a 0x00 write (ignored).
  - io_buffer_full rises after the 6th push.
  - 9th nonzero write dropped; count stays 8.
  - Then tx_ready=1 -> bytes emerge in order 0x31..0x38.
- Stop: write 0x30004 with 2 bytes queued and tx_ready=1 -> the 0x00 byte is transmitted last.
  - halted=1 the cycle after the FIFO empties.
  - A subsequent RAM write to 0x00020 is ignored (a read returns the old value).
- Reset mid-DRAIN: rst_in=1 for 1 cycle -> tx_valid=0, halted=0, state RUN, prior RAM data still readable.

Source files
------------

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU external memory bus target: byte RAM, UART RX/TX, cycle counter, stop register
// Optional MEMIO_ERR_FLAG_EN adds a sticky bus_err output.
module mem_io_responder #(
    parameter int RAM_ADDR_BITS = 17,
    parameter int TX_DEPTH      = 8,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        io_buffer_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halted
`ifdef MEMIO_ERR_FLAG_EN
    ,
    output logic        bus_err
`endif
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t state, state_next;

    logic [7:0]               ram [0:(1 << RAM_ADDR_BITS) - 1];
    logic [7:0]               fifo [0:TX_DEPTH - 1];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count, count_next;
    logic [31:0]              counter, snap;
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    logic [15:0]              io_off;
    logic                     is_io;
    logic                     fifo_full, push_req, push, pop, stop_accept, ram_we;
    logic [7:0]               push_byte, io_rdata;
    logic                     unused_addr_hi;

    assign is_io          = (cpu_a[17:16] == 2'b11);
    assign io_off         = cpu_a[15:0];
    assign ram_idx        = cpu_a[RAM_ADDR_BITS-1:0];
    assign unused_addr_hi = ^cpu_a[31:18];

    assign tx_valid  = (count != '0);
    assign tx_data   = fifo[rd_ptr];
    assign halted    = (state == ST_HALTED);
    assign fifo_full = (count == CW'(TX_DEPTH));
    assign pop       = tx_valid & tx_ready;

    // A push into a full FIFO still lands if the head leaves in the same cycle.
    assign push_req    = (state == ST_RUN) && is_io && cpu_wr &&
                         (((io_off == 16'h0000) && (cpu_wdata != 8'h00)) || (io_off == 16'h0004));
    assign push        = push_req && (!fifo_full || pop);
    assign push_byte   = (io_off == 16'h0004) ? 8'h00 : cpu_wdata;
    assign stop_accept = push && (io_off == 16'h0004);

    assign rx_ready = !rst_in && is_io && !cpu_wr && (io_off == 16'h0000) && rx_valid;
    assign ram_we   = !rst_in && cpu_wr && !is_io && (state != ST_HALTED);

    always_comb begin
        io_rdata = 8'h00;
        case (io_off)
            16'h0000: io_rdata = rx_valid ? rx_data : 8'h00;
            16'h0004: io_rdata = counter[7:0];
            16'h0005: io_rdata = snap[15:8];
            16'h0006: io_rdata = snap[23:16];
            16'h0007: io_rdata = snap[31:24];
            default:  io_rdata = 8'h00;
        endcase
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (stop_accept) state_next = ST_DRAIN;
            ST_DRAIN:  if (count == '0) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_idx] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cpu_rdata <= 8'h00;
            snap      <= 32'h0;
        end else if (!cpu_wr) begin
            cpu_rdata <= is_io ? io_rdata : ram[ram_idx];
            if (is_io && (io_off == 16'h0004)) begin
                snap <= counter;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            counter <= 32'h0;
        end else begin
            counter <= counter + 32'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            fifo[wr_ptr] <= push_byte;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count          <= count_next;
            io_buffer_full <= (CW'(TX_DEPTH) - count_next) <= CW'(FULL_MARGIN);
        end
    end

`ifdef MEMIO_ERR_FLAG_EN
    logic io_defined, err_event;

    assign io_defined = (io_off == 16'h0000) ||
                        ((io_off >= 16'h0004) && (io_off <= 16'h0007));
    assign err_event  = (!is_io && (cpu_a[31:RAM_ADDR_BITS] != '0)) ||
                        (is_io && !io_defined) ||
                        (push_req && !push);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus_err <= 1'b0;
        end else if (err_event) begin
            bus_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed and random checks of mem_io_responder against a queue-based model
module tb_mem_io_responder;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  wd;
    logic [7:0]  rdata;
    logic        full;
    logic [7:0]  rxd;
    logic        rxv;
    logic        rxr;
    logic [7:0]  txd;
    logic        txv;
    logic        txr;
    logic        hlt;

    always #5 clk = ~clk;

    mem_io_responder #(
        .RAM_ADDR_BITS(17),
        .TX_DEPTH(DEPTH),
        .FULL_MARGIN(MARGIN)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .cpu_a(a),
        .cpu_wr(wr),
        .cpu_wdata(wd),
        .cpu_rdata(rdata),
        .io_buffer_full(full),
        .rx_data(rxd),
        .rx_valid(rxv),
        .rx_ready(rxr),
        .tx_data(txd),
        .tx_valid(txv),
        .tx_ready(txr),
        .halted(hlt)
    );

    logic [7:0]  m_ram [int];
    logic [7:0]  m_q [$];
    logic [7:0]  obs_tx [$];
    logic [31:0] m_cnt = 32'h0;
    logic [31:0] m_snap = 32'h0;
    logic [7:0]  m_rdata = 8'h00;
    bit          m_rd_known = 1'b0;
    bit          m_full = 1'b0;
    int          m_mode = 0;   // 0 running, 1 stopping, 2 stopped
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [15:0] off;
        logic [7:0]  tmp;
        bit          io, pop, stop_now;
        int          idx, old_n;
        if (rst) begin
            m_rdata = 8'h00; m_rd_known = 1'b1; m_q.delete(); m_cnt = 32'h0;
            m_snap = 32'h0; m_mode = 0; m_full = 1'b0;
            return;
        end
        io       = (a[17:16] == 2'b11);
        off      = a[15:0];
        idx      = int'(a[16:0]);
        old_n    = m_q.size();
        pop      = (old_n > 0) && txr;
        stop_now = 1'b0;
        if (!wr) begin
            if (io) begin
                case (off)
                    16'h0000: m_rdata = rxv ? rxd : 8'h00;
                    16'h0004: begin m_snap = m_cnt; m_rdata = m_cnt[7:0]; end
                    16'h0005: m_rdata = m_snap[15:8];
                    16'h0006: m_rdata = m_snap[23:16];
                    16'h0007: m_rdata = m_snap[31:24];
                    default:  m_rdata = 8'h00;
                endcase
                m_rd_known = 1'b1;
            end else if (m_ram.exists(idx)) begin
                m_rdata = m_ram[idx]; m_rd_known = 1'b1;
            end else begin
                m_rd_known = 1'b0;
            end
        end else if (!io && m_mode != 2) begin
            m_ram[idx] = wd;
        end
        if (pop) tmp = m_q.pop_front();
        if (wr && io && m_mode == 0 && ((off == 16'h0000 && wd != 8'h00) || off == 16'h0004)) begin
            if (old_n < DEPTH || pop) begin
                m_q.push_back(off == 16'h0004 ? 8'h00 : wd);
                stop_now = (off == 16'h0004);
            end
        end
        if (m_mode == 1 && old_n == 0) m_mode = 2;
        else if (stop_now) m_mode = 1;
        m_full = (DEPTH - m_q.size()) <= MARGIN;
        m_cnt++;
    endtask

    task automatic cycle(input logic [31:0] ca, input logic cw, input logic [7:0] cd);
        a = ca; wr = cw; wd = cd;
        #2;
        chk("rx_ready", 32'(rxr), 32'(!rst && !cw && ca[17:16] == 2'b11 && ca[15:0] == 16'h0 && rxv));
        if (txv && txr) obs_tx.push_back(txd);
        model_step();
        @(posedge clk);
        #1;
        if (m_rd_known) chk("cpu_rdata", 32'(rdata), 32'(m_rdata));
        chk("tx_valid", 32'(txv), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("tx_data", 32'(txd), 32'(m_q[0]));
        chk("io_buffer_full", 32'(full), 32'(m_full));
        chk("halted", 32'(hlt), 32'(m_mode == 2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [16:0] pool [8] = '{17'h00010, 17'h00020, 17'h0ABCD, 17'h0FFFF,
                                   17'h00000, 17'h01234, 17'h0F00F, 17'h00777};
        logic [15:0] offs [8] = '{16'h0000, 16'h0000, 16'h0004, 16'h0005,
                                   16'h0006, 16'h0007, 16'h0008, 16'h0002};
        rst = 1'b1; a = 32'h0; wr = 1'b0; wd = 8'h00; rxv = 1'b0; rxd = 8'h00; txr = 1'b0;
        cycle(32'h0, 1'b0, 8'h00);
        cycle(32'h0, 1'b0, 8'h00);
        rst = 1'b0;
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_tx_valid", 32'(txv), 32'h0);
        chk("rst_halted", 32'(hlt), 32'h0);
        chk("rst_full", 32'(full), 32'h0);

        foreach (pool[k]) cycle(32'(pool[k]), 1'b1, 8'(8'h11 * (k + 1)));
        cycle(32'h00000, 1'b1, 8'h3C);

        // RAM: write leaves cpu_rdata alone, read data one cycle later
        cycle(32'h00000, 1'b0, 8'h00);
        chk("ram_read_prev", 32'(rdata), 32'h3C);
        cycle(32'h00010, 1'b1, 8'hA5);
        chk("ram_wr_hold", 32'(rdata), 32'h3C);
        cycle(32'h00010, 1'b0, 8'h00);
        chk("ram_latency", 32'(rdata), 32'hA5);

        // RX path
        rxv = 1'b1; rxd = 8'h41;
        cycle(32'h30000, 1'b0, 8'h00);
        chk("rx_byte", 32'(rdata), 32'h41);
        cycle(32'h00010, 1'b0, 8'h00);
        rxv = 1'b0;
        cycle(32'h30000, 1'b0, 8'h00);
        chk("rx_empty", 32'(rdata), 32'h0);

        // counter snapshot at 0x1FF
        rst = 1'b1; cycle(32'h10, 1'b0, 8'h00); rst = 1'b0;
        for (int i = 0; i < 1000 && m_cnt != 32'h1FF; i++) cycle(32'h10, 1'b0, 8'h00);
        cycle(32'h00030004, 1'b0, 8'h00); chk("snap_b0", 32'(rdata), 32'hFF);
        cycle(32'h00030005, 1'b0, 8'h00); chk("snap_b1", 32'(rdata), 32'h01);
        cycle(32'hABC30006, 1'b0, 8'h00); chk("snap_b2", 32'(rdata), 32'h00);
        cycle(32'h00030007, 1'b0, 8'h00); chk("snap_b3", 32'(rdata), 32'h00);

        // TX FIFO fill, full flag, drop, ordered drain
        txr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(32'h30000, 1'b1, 8'(8'h31 + i));
            if (i == 4) chk("full_after5", 32'(full), 32'h0);
            if (i == 5) chk("full_after6", 32'(full), 32'h1);
        end
        cycle(32'h30000, 1'b1, 8'h00);
        cycle(32'h30000, 1'b1, 8'h39);
        obs_tx.delete();
        txr = 1'b1;
        for (int i = 0; i < 11; i++) cycle(32'h10, 1'b0, 8'h00);
        chk("tx_count", 32'(obs_tx.size()), 32'd8);
        for (int i = 0; i < 8 && i < obs_tx.size(); i++)
            chk("tx_order", 32'(obs_tx[i]), 32'(32'h31 + i));

        // stop sequence
        txr = 1'b0;
        cycle(32'h00020, 1'b1, 8'h77);
        obs_tx.delete();
        cycle(32'h30000, 1'b1, 8'h51);
        cycle(32'h30000, 1'b1, 8'h52);
        txr = 1'b1;
        cycle(32'h30004, 1'b1, 8'hEE);
        for (int i = 0; i < 40 && !hlt; i++) cycle(32'h10, 1'b0, 8'h00);
        chk("halt_reached", 32'(hlt), 32'h1);
        chk("stop_count", 32'(obs_tx.size()), 32'd3);
        if (obs_tx.size() == 3) begin
            chk("stop_b0", 32'(obs_tx[0]), 32'h51);
            chk("stop_b1", 32'(obs_tx[1]), 32'h52);
            chk("stop_b2", 32'(obs_tx[2]), 32'h00);
        end
        cycle(32'h00020, 1'b1, 8'h88);
        cycle(32'h00020, 1'b0, 8'h00);
        chk("halt_wr_ignored", 32'(rdata), 32'h77);

        // reset while draining
        rst = 1'b1; cycle(32'h10, 1'b0, 8'h00); rst = 1'b0;
        txr = 1'b0;
        cycle(32'h30000, 1'b1, 8'h61);
        cycle(32'h30004, 1'b1, 8'h00);
        rst = 1'b1; cycle(32'h10, 1'b0, 8'h00); rst = 1'b0;
        chk("rst_drain_txv", 32'(txv), 32'h0);
        chk("rst_drain_halt", 32'(hlt), 32'h0);
        cycle(32'h00020, 1'b0, 8'h00);
        chk("ram_kept", 32'(rdata), 32'h77);
        cycle(32'h30000, 1'b1, 8'h62);
        chk("run_after_rst", 32'(txv), 32'h1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ca;
            logic        cw;
            logic [7:0]  cd;
            int          kind;
            rst  = ($urandom_range(0, 63) == 0);
            rxv  = 1'($urandom);
            rxd  = 8'($urandom);
            txr  = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 9);
            cw   = 1'($urandom);
            cd   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            if (kind < 5) begin
                ca = {15'($urandom), pool[$urandom_range(0, 7)]};
            end else begin
                ca = {14'($urandom), 2'b11, offs[$urandom_range(0, 7)]};
                if (cw && ca[15:0] == 16'h0004 && $urandom_range(0, 7) != 0) cw = 1'b0;
            end
            cycle(ca, cw, cd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
